// File: rtl/alu_pkg.sv
// Shared opcodes, error codes, state encodings and command screening for the ALU command sequencer.
package alu_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_RES_W  = DEF_DATA_W + 1;
    localparam int unsigned ERR_CNT_W  = 8;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_PASS = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_XNOR = 4'd9;
    localparam logic [3:0] OP_ASR  = 4'd10;
    localparam logic [3:0] OP_ASL  = 4'd11;
    localparam logic [3:0] OP_LSR  = 4'd12;
    localparam logic [3:0] OP_LSL  = 4'd13;
    localparam logic [3:0] OP_MAX  = OP_LSL;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_DIV0    = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Illegal opcode outranks divide-by-zero.
    function automatic logic [1:0] screen_cmd(input logic [3:0] opr, input logic b_zero);
        if (opr > OP_MAX) return ERR_ILLEGAL;
        if ((opr == OP_DIV) && b_zero) return ERR_DIV0;
        return ERR_OK;
    endfunction

endpackage

// File: rtl/alu_seq_stats.sv
// Saturating counters of issued and rejected commands.
module alu_seq_stats
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_op,
    input  logic                 inc_err,
    output logic [CNT_W-1:0]     op_count,
    output logic [ERR_CNT_W-1:0] err_count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count  <= '0;
            err_count <= '0;
        end else begin
            if (inc_op && (op_count != '1)) begin
                op_count <= op_count + CNT_W'(1);
            end
            if (inc_err && (err_count != '1)) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues screened commands to a combinational ALU, waits SETTLE cycles, and returns
// the captured result with an error code over a valid/ready response channel.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RES_W  = DEF_RES_W,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [DATA_W-1:0]    cmd_a,
    input  logic [DATA_W-1:0]    cmd_b,
    input  logic [3:0]           cmd_opr,
    input  logic                 cmd_sel,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_b,
    output logic [3:0]           alu_opr,
    output logic                 alu_sel,
    input  logic [RES_W-1:0]     alu_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RES_W-1:0]     rsp_data,
    output logic [1:0]           rsp_err,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned SC_W = $clog2(SETTLE + 1);

    logic [1:0]        state, state_d;
    logic [SC_W-1:0]   cnt, cnt_d;
    logic [DATA_W-1:0] alu_a_d, alu_b_d;
    logic [3:0]        alu_opr_d;
    logic              alu_sel_d;
    logic              rsp_valid_d;
    logic [RES_W-1:0]  rsp_data_d;
    logic [1:0]        rsp_err_d;
    logic [1:0]        screen_err;
    logic              inc_op, inc_err;

    assign cmd_ready  = (state == ST_IDLE) && !rst;
    assign screen_err = screen_cmd(cmd_opr, cmd_b == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_opr   <= '0;
            alu_sel   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= ERR_OK;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            alu_opr   <= alu_opr_d;
            alu_sel   <= alu_sel_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
            busy      <= (state_d != ST_IDLE);
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        alu_a_d     = alu_a;
        alu_b_d     = alu_b;
        alu_opr_d   = alu_opr;
        alu_sel_d   = alu_sel;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;
        inc_op      = 1'b0;
        inc_err     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (screen_err != ERR_OK) begin
                        // Rejected commands answer at once and leave the ALU ports untouched.
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = screen_err;
                        inc_err     = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        alu_a_d   = cmd_a;
                        alu_b_d   = cmd_b;
                        alu_opr_d = cmd_opr;
                        alu_sel_d = cmd_sel;
                        cnt_d     = SC_W'(SETTLE);
                        state_d   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt - SC_W'(1);
                if (cnt == SC_W'(1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = alu_out;
                    rsp_err_d   = ERR_OK;
                    inc_op      = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    alu_seq_stats #(.CNT_W(CNT_W)) u_stats (
        .clk       (clk),
        .rst       (rst),
        .inc_op    (inc_op),
        .inc_err   (inc_err),
        .op_count  (op_count),
        .err_count (err_count)
    );

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench: a behavioural ALU sits on the alu_* ports; expected responses are queued at accept.
module tb_alu_cmd_sequencer;

    localparam int unsigned SETTLE = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_a = '0, cmd_b = '0;
    logic [3:0]  cmd_opr = '0;
    logic        cmd_sel = 1'b0;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_opr;
    logic        alu_sel;
    logic [8:0]  alu_out;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [8:0]  rsp_data;
    logic [1:0]  rsp_err;
    logic        busy;
    logic [15:0] op_count;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hold_cnt = 0;
    bit rand_rdy = 1'b0;

    typedef struct {
        logic [8:0] data;
        logic [1:0] err;
        int         due;
        int         opc;
        int         erc;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic       sel;
    } exp_t;

    exp_t       q[$];
    logic [8:0] got_data[$];
    logic [1:0] got_err[$];

    int         m_op = 0, m_err = 0;
    logic [7:0] m_a = '0, m_b = '0;
    logic [3:0] m_opr = '0;
    logic       m_sel = 1'b0;

    // Behavioural ALU: integer arithmetic, result reduced modulo 512.
    function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op, input logic sel);
        int ia, ib, s, r;
        ia = int'(a);
        ib = int'(b);
        s  = sel ? ia : ib;
        case (op)
            4'd0:    r = ia + ib;
            4'd1:    r = ia - ib;
            4'd2:    r = ia * ib;
            4'd3:    r = (ib == 0) ? 0 : ia / ib;
            4'd4:    r = s;
            4'd5:    r = 255 - (ia & ib);
            4'd6:    r = ia & ib;
            4'd7:    r = ia | ib;
            4'd8:    r = ia ^ ib;
            4'd9:    r = 255 - (ia ^ ib);
            4'd10:   r = (s / 2) + ((s >= 128) ? 128 : 0);
            4'd11:   r = s * 2;
            4'd12:   r = s / 2;
            4'd13:   r = s * 2;
            default: r = 0;
        endcase
        r = r % 512;
        if (r < 0) r = r + 512;
        return 9'(r);
    endfunction

    assign alu_out = alu_ref(alu_a, alu_b, alu_opr, alu_sel);

    alu_cmd_sequencer #(.DATA_W(8), .RES_W(9), .SETTLE(SETTLE), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_opr   (cmd_opr),
        .cmd_sel   (cmd_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_opr   (alu_opr),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .op_count  (op_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Response back-pressure: forced-low window, otherwise always-ready or random.
    initial forever begin
        @(posedge clk);
        #1;
        if (hold_cnt > 0) begin
            rsp_ready = 1'b0;
            hold_cnt--;
        end else begin
            rsp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Drives one command (call at posedge+1) and queues its expected response at accept.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input logic sel);
        exp_t e;
        bit   accepted;
        int   er;
        accepted  = 1'b0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_opr   = op;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (cmd_ready) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual cmd_ready=0 required cmd_ready=1 within 200 cycles");
        end else begin
            er = (int'(op) > 13) ? 1 : ((int'(op) == 3 && b == 8'd0) ? 2 : 0);
            if (er == 0) begin
                m_op   = (m_op < 65535) ? m_op + 1 : 65535;
                m_a    = a;
                m_b    = b;
                m_opr  = op;
                m_sel  = sel;
                e.data = alu_ref(a, b, op, sel);
                e.due  = cyc + 1 + int'(SETTLE);
            end else begin
                m_err  = (m_err < 255) ? m_err + 1 : 255;
                e.data = 9'd0;
                e.due  = cyc + 1;
            end
            e.err = 2'(er);
            e.opc = m_op;
            e.erc = m_err;
            e.a   = m_a;
            e.b   = m_b;
            e.op  = m_opr;
            e.sel = m_sel;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_a     = 8'($urandom);
        cmd_b     = 8'($urandom);
        cmd_opr   = 4'($urandom);
        cmd_sel   = 1'($urandom);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (q.size() == 0 && !rsp_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual pending=%0d required pending=0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every presented response against the head of the scoreboard.
    initial begin
        bit   prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                check("busy_vs_ready", 32'(busy), 32'(!cmd_ready));
                if (rsp_valid) begin
                    check("ready_in_resp", 32'(cmd_ready), 32'd0);
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp actual rsp_valid=1 required rsp_valid=0 (cycle %0d)", cyc);
                    end else begin
                        e = q[0];
                        if (!prev_v) begin
                            check("latency", 32'(cyc), 32'(e.due));
                            check("op_count", 32'(op_count), 32'(e.opc));
                            check("err_count", 32'(err_count), 32'(e.erc));
                            check("alu_a", 32'(alu_a), 32'(e.a));
                            check("alu_b", 32'(alu_b), 32'(e.b));
                            check("alu_opr", 32'(alu_opr), 32'(e.op));
                            check("alu_sel", 32'(alu_sel), 32'(e.sel));
                        end
                        check("rsp_data", 32'(rsp_data), 32'(e.data));
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        if (rsp_ready) begin
                            got_data.push_back(rsp_data);
                            got_err.push_back(rsp_err);
                            void'(q.pop_front());
                        end
                    end
                end
                prev_v = rsp_valid;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        issue(8'd200, 8'd100, 4'd0, 1'b0);
        wait_idle();
        check("add_data", 32'(got_data[$]), 32'd300);
        check("add_err", 32'(got_err[$]), 32'd0);
        check("add_op_count", 32'(op_count), 32'd1);

        issue(8'd20, 8'd30, 4'd2, 1'b0);
        wait_idle();
        check("mul_wrap_data", 32'(got_data[$]), 32'd88);

        issue(8'd7, 8'd0, 4'd3, 1'b0);
        wait_idle();
        check("div0_err", 32'(got_err[$]), 32'd2);
        check("div0_data", 32'(got_data[$]), 32'd0);
        check("div0_err_count", 32'(err_count), 32'd1);
        check("div0_alu_opr_kept", 32'(alu_opr), 32'd2);
        issue(8'd5, 8'd5, 4'd14, 1'b0);
        wait_idle();
        check("illegal_err", 32'(got_err[$]), 32'd1);
        check("illegal_err_count", 32'(err_count), 32'd2);

        hold_cnt = int'(SETTLE) + 6;
        issue(8'h81, 8'h33, 4'd12, 1'b1);
        issue(8'd10, 8'd20, 4'd1, 1'b0);
        wait_idle();
        check("bp_lsr_data", 32'(got_data[got_data.size() - 2]), 32'h040);
        check("bp_second_sub", 32'(got_data[$]), 32'h1F6);

        issue(8'h5A, 8'h0F, 4'd6, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_alu_a", 32'(alu_a), 32'd0);
        check("mid_rst_alu_b", 32'(alu_b), 32'd0);
        check("mid_rst_alu_opr", 32'(alu_opr), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_op_count", 32'(op_count), 32'd0);
        check("mid_rst_err_count", 32'(err_count), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        q.delete();
        m_op  = 0;
        m_err = 0;
        m_a   = '0;
        m_b   = '0;
        m_opr = '0;
        m_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        issue(8'd50, 8'd20, 4'd1, 1'b0);
        wait_idle();
        check("post_rst_data", 32'(got_data[$]), 32'd30);
        check("post_rst_op_count", 32'(op_count), 32'd1);

        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [7:0] ra, rb;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            issue(ra, rb, 4'($urandom_range(0, 15)), 1'($urandom));
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
